jacobi_sequencer: RTL and testbench

//  Sequences grid_solver over full Jacobi sweeps of the phi grid.

---
 rtl/jacobi_sequencer.sv | 165 ++++++++++++++++
 tb/tb_jacobi_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_sequencer.sv
// Sequencer for full Jacobi sweeps: raster-order address issue with hold throttling,
// count-based drain detection, ping-pong bank flip and iteration control.
module jacobi_sequencer #(
    parameter int unsigned GRID_X = 64,
    parameter int unsigned GRID_Y = 64,
    parameter int unsigned XW     = $clog2(GRID_X),
    parameter int unsigned YW     = $clog2(GRID_Y),
    parameter int unsigned ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iters,
    input  logic              hold,
    input  logic              wb_valid,
    output logic              solve_valid,
    output logic [YW+XW-1:0]  solve_addr,
    output logic              bank_sel,
    output logic [ITER_W-1:0] iter_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned NPTS = GRID_X * GRID_Y;
    localparam int unsigned CW   = $clog2(NPTS + 1);

    localparam logic [CW-1:0] NPTS_C = CW'(NPTS);
    localparam logic [XW-1:0] X_LAST = XW'(GRID_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_Y - 1);

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StSwap, StDone} state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CW-1:0]     wb_cnt_q, wb_cnt_d;
    logic [ITER_W-1:0] n_iters_q, n_iters_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              bank_q, bank_d;
    logic              valid_q, valid_d;
    logic [YW+XW-1:0]  addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wb_full;

    assign wb_full = (wb_cnt_q == NPTS_C);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        wb_cnt_d  = wb_cnt_q;
        n_iters_d = n_iters_q;
        iter_d    = iter_q;
        bank_d    = bank_q;
        valid_d   = 1'b0;
        addr_d    = addr_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_iters_d = num_iters;
                    iter_d    = '0;
                    x_d       = '0;
                    y_d       = '0;
                    wb_cnt_d  = '0;
                    state_d   = (num_iters == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                busy_d = 1'b1;
                if (!hold) begin
                    valid_d = 1'b1;
                    addr_d  = {y_q, x_q};
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = StDrain;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            StDrain: begin
                busy_d = 1'b1;
                if (wb_full) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                busy_d   = 1'b1;
                bank_d   = ~bank_q;
                wb_cnt_d = '0;
                if (iter_q == n_iters_q - ITER_W'(1)) begin
                    state_d = StDone;
                end else begin
                    iter_d  = iter_q + ITER_W'(1);
                    state_d = StIssue;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Write-backs only count while a sweep is outstanding; anything else is a stray strobe.
        if (wb_valid) begin
            if ((state_q == StIssue || state_q == StDrain) && !wb_full) begin
                wb_cnt_d = wb_cnt_q + CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            wb_cnt_q  <= '0;
            n_iters_q <= '0;
            iter_q    <= '0;
            bank_q    <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wb_cnt_q  <= wb_cnt_d;
            n_iters_q <= n_iters_d;
            iter_q    <= iter_d;
            bank_q    <= bank_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign solve_valid = valid_q;
    assign solve_addr  = addr_q;
    assign bank_sel    = bank_q;
    assign iter_idx    = iter_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_jacobi_sequencer.sv
// Self-checking bench for jacobi_sequencer on a 4x4 grid with a fixed-latency solver echo.
module tb_jacobi_sequencer;

    localparam int GX   = 4;
    localparam int GY   = 4;
    localparam int XW   = 2;
    localparam int YW   = 2;
    localparam int IW   = 8;
    localparam int NPTS = GX * GY;
    localparam int DLY  = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] num_iters = '0;
    logic          hold = 1'b0;
    logic          wb_valid;
    logic          solve_valid;
    logic [YW+XW-1:0] solve_addr;
    logic          bank_sel;
    logic [IW-1:0] iter_idx;
    logic          busy;
    logic          done;
    logic          err;

    logic [31:0]   hist;
    logic          wb_force = 1'b0;

    jacobi_sequencer #(
        .GRID_X (GX),
        .GRID_Y (GY),
        .XW     (XW),
        .YW     (YW),
        .ITER_W (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_iters   (num_iters),
        .hold        (hold),
        .wb_valid    (wb_valid),
        .solve_valid (solve_valid),
        .solve_addr  (solve_addr),
        .bank_sel    (bank_sel),
        .iter_idx    (iter_idx),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Solver stand-in: echoes each issued address as a write-back DLY cycles later.
    always @(posedge clk) begin
        if (rst) hist <= '0;
        else     hist <= {hist[30:0], solve_valid};
    end
    assign wb_valid = hist[DLY-1] | wb_force;

    typedef struct {
        int   ni;
        int   hlo;
        int   hhi;
        int   exp_done;
        logic exp_bank;
        logic pre_err;
        int   restart_at;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; hold = 1'b0; wb_force = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".solve_valid"}, int'(solve_valid), 0);
        chk({tag, ".solve_addr"},  int'(solve_addr),  0);
        chk({tag, ".busy"},        int'(busy),        0);
        chk({tag, ".done"},        int'(done),        0);
        chk({tag, ".bank_sel"},    int'(bank_sel),    0);
        chk({tag, ".iter_idx"},    int'(iter_idx),    0);
        chk({tag, ".err"},         int'(err),         0);
    endtask

    task automatic run_vec(input vec_t v, input int row);
        int    issued = 0;
        int    wbs = 0;
        int    dones = 0;
        int    done_cyc = -1;
        int    hlen;
        string tag;
        tag  = $sformatf("row%0d", row);
        hlen = (v.hhi >= v.hlo) ? (v.hhi - v.hlo + 1) : 0;

        do_reset();
        chk_zero({tag, ".reset"});
        if (v.pre_err) begin
            wb_force = 1'b1;
            @(posedge clk);
            @(negedge clk);
            wb_force = 1'b0;
            chk({tag, ".err_idle_wb"}, int'(err), 1);
        end

        num_iters = IW'(v.ni);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;

        for (int c = 1; c <= 400; c++) begin
            hold  = (c >= v.hlo && c <= v.hhi);
            start = (c == v.restart_at);
            if (start) num_iters = IW'(v.ni + 2);
            @(posedge clk);
            @(negedge clk);
            if (v.ni > 0 && c <= NPTS + hlen)
                chk($sformatf("%s.sv_c%0d", tag, c), int'(solve_valid),
                    (c >= v.hlo && c <= v.hhi) ? 0 : 1);
            if (solve_valid) begin
                chk($sformatf("%s.addr%0d", tag, issued), int'(solve_addr), issued % NPTS);
                chk($sformatf("%s.iter%0d", tag, issued), int'(iter_idx), issued / NPTS);
                chk($sformatf("%s.drained%0d", tag, issued),
                    int'(wbs >= NPTS * (issued / NPTS)), 1);
                issued++;
            end
            if (wb_valid) wbs++;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    chk({tag, ".busy_at_done"}, int'(busy), 0);
                    chk({tag, ".bank_at_done"}, int'(bank_sel), int'(v.exp_bank));
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
        hold  = 1'b0;

        chk({tag, ".done_cycle"}, done_cyc, v.exp_done);
        chk({tag, ".done_count"}, dones, 1);
        chk({tag, ".issued"},     issued, NPTS * v.ni);
        chk({tag, ".wb_count"},   wbs, NPTS * v.ni);
        chk({tag, ".err_end"},    int'(err), int'(v.pre_err));
        chk({tag, ".bank_end"},   int'(bank_sel), int'(v.exp_bank));
    endtask

    initial begin
        // ni, hold lo, hold hi, done cycle, final bank, stray wb first, mid-run start
        vecs[0] = '{1, 0, -1,  42, 1'b1, 1'b0, 0};
        vecs[1] = '{3, 0, -1, 124, 1'b1, 1'b0, 0};
        vecs[2] = '{1, 5,  9,  47, 1'b1, 1'b0, 0};
        vecs[3] = '{0, 0, -1,   1, 1'b0, 1'b0, 0};
        vecs[4] = '{2, 5,  9,  88, 1'b0, 1'b0, 0};
        vecs[5] = '{1, 0, -1,  42, 1'b1, 1'b1, 10};

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset mid-issue aborts the sweep; a fresh start begins again at (0,0).
        do_reset();
        chk_zero("abort.reset");
        num_iters = 8'd1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort.pre_valid", int'(solve_valid), 1);
        chk("abort.pre_addr",  int'(solve_addr), 6);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("abort.after_rst");
        rst = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("restart.busy", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        chk("restart.valid", int'(solve_valid), 1);
        chk("restart.addr",  int'(solve_addr), 0);
        chk("restart.busy1", int'(busy), 1);

        do_reset();
        chk_zero("final.reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
